mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the I-cache refill path
// and the data-memory path. One requester is granted at a time; the winner's
// address, write data and byte enables are latched on the grant edge and held
// on the memory port for the whole transaction. The memory response comes
// back to the owner as a single-cycle ready pulse with combinational data.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   -> on simultaneous requests the side not granted last wins
//                (last-owner bit resets to I, so D wins the first tie).
//   undefined -> fixed D-over-I priority.
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-low reset
//   i_IReq, i_IAddr      I-side refill request/address (held until o_IReady)
//   o_IData, o_IReady    I-side refill block and completion pulse
//   i_DReq, i_DWe, i_DAddr, i_DWData, i_DByteEn
//                        D-side request (held until o_DReady)
//   o_DData, o_DReady    D-side read word and completion pulse
//   o_MemReq, o_MemWe, o_MemAddr, o_MemWData, o_MemByteEn
//                        memory request port (latched fields)
//   i_MemData, i_MemReady memory response block and completion pulse
//   o_Err                sticky watchdog error flag
`ifndef XLEN
`define XLEN 32
`endif

module mem_arbiter #(
  parameter int BLOCK_SIZE = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_IReq,
  input  logic [`XLEN-1:0]         i_IAddr,
  output logic [BLOCK_SIZE*32-1:0] o_IData,
  output logic                     o_IReady,
  input  logic                     i_DReq,
  input  logic                     i_DWe,
  input  logic [`XLEN-1:0]         i_DAddr,
  input  logic [31:0]              i_DWData,
  input  logic [3:0]               i_DByteEn,
  output logic [31:0]              o_DData,
  output logic                     o_DReady,
  output logic                     o_MemReq,
  output logic                     o_MemWe,
  output logic [`XLEN-1:0]         o_MemAddr,
  output logic [31:0]              o_MemWData,
  output logic [3:0]               o_MemByteEn,
  input  logic [BLOCK_SIZE*32-1:0] i_MemData,
  input  logic                     i_MemReady,
  output logic                     o_Err
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WD_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [`XLEN-1:0] ALIGN_MASK = ~(`XLEN'(3));

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [`XLEN-1:0]   addr_q, addr_d;
  logic               we_q, we_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               grant_i, grant_d;
  logic               wd_fire;
  logic [31:0]        rd_word;
`ifdef ARB_ROUND_ROBIN_EN
  logic               last_d_q, last_d_d;
`endif

  // Word of the returned block addressed by the latched D-side address.
  if (BLOCK_SIZE > 1) begin : g_wsel
    localparam int WS = $clog2(BLOCK_SIZE);
    logic [WS-1:0] w;
    assign w       = addr_q[2 +: WS];
    assign rd_word = i_MemData[{w, 5'b00000} +: 32];
  end else begin : g_wsel1
    assign rd_word = i_MemData[31:0];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      be_q     <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q <= last_d_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d_d = last_d_q;
`endif
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    wd_fire  = 1'b0;
    o_IReady = 1'b0;
    o_DReady = 1'b0;
    o_IData  = '0;
    o_DData  = '0;

    case (state_q)
      IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
        if (i_DReq && i_IReq) begin
          grant_i = last_d_q;
          grant_d = !last_d_q;
        end else begin
          grant_d = i_DReq;
          grant_i = i_IReq;
        end
`else
        grant_d = i_DReq;
        grant_i = i_IReq && !i_DReq;
`endif
        if (grant_d) begin
          state_d  = SERVE_D;
          addr_d   = i_DAddr & ALIGN_MASK;
          we_d     = i_DWe;
          wdata_d  = i_DWData;
          be_d     = i_DByteEn;
          cnt_d    = '0;
`ifdef ARB_ROUND_ROBIN_EN
          last_d_d = 1'b1;
`endif
        end else if (grant_i) begin
          state_d  = SERVE_I;
          addr_d   = i_IAddr & ALIGN_MASK;
          we_d     = 1'b0;
          wdata_d  = '0;
          be_d     = 4'hF;
          cnt_d    = '0;
`ifdef ARB_ROUND_ROBIN_EN
          last_d_d = 1'b0;
`endif
        end
      end

      SERVE_I, SERVE_D: begin
        // A memory response in the timeout cycle wins over the watchdog.
        wd_fire = WD_EN && (cnt_q == TO_CNT) && !i_MemReady;
        if (i_MemReady || wd_fire) begin
          state_d = IDLE;
          if (wd_fire) err_d = 1'b1;
          // Ready is suppressed while reset is being applied.
          if (state_q == SERVE_I) begin
            o_IReady = i_rst;
            if (!wd_fire && i_rst) o_IData = i_MemData;
          end else begin
            o_DReady = i_rst;
            if (!wd_fire && !we_q && i_rst) o_DData = rd_word;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign o_MemReq    = (state_q != IDLE);
  assign o_MemWe     = we_q;
  assign o_MemAddr   = addr_q;
  assign o_MemWData  = wdata_q;
  assign o_MemByteEn = be_q;
  assign o_Err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
`ifndef XLEN
`define XLEN 32
`endif

module tb_mem_arbiter;

  localparam int BS = 2;
  localparam int BW = BS * 32;
  localparam int TO = 8;

  logic              clk;
  logic              i_rst;
  logic              i_IReq;
  logic [`XLEN-1:0]  i_IAddr;
  logic [BW-1:0]     o_IData;
  logic              o_IReady;
  logic              i_DReq;
  logic              i_DWe;
  logic [`XLEN-1:0]  i_DAddr;
  logic [31:0]       i_DWData;
  logic [3:0]        i_DByteEn;
  logic [31:0]       o_DData;
  logic              o_DReady;
  logic              o_MemReq;
  logic              o_MemWe;
  logic [`XLEN-1:0]  o_MemAddr;
  logic [31:0]       o_MemWData;
  logic [3:0]        o_MemByteEn;
  logic [BW-1:0]     i_MemData;
  logic              i_MemReady;
  logic              o_Err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          is_d;
    logic [BW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  mem_arbiter #(.BLOCK_SIZE(BS), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_IReq(i_IReq), .i_IAddr(i_IAddr), .o_IData(o_IData), .o_IReady(o_IReady),
    .i_DReq(i_DReq), .i_DWe(i_DWe), .i_DAddr(i_DAddr), .i_DWData(i_DWData),
    .i_DByteEn(i_DByteEn), .o_DData(o_DData), .o_DReady(o_DReady),
    .o_MemReq(o_MemReq), .o_MemWe(o_MemWe), .o_MemAddr(o_MemAddr),
    .o_MemWData(o_MemWData), .o_MemByteEn(o_MemByteEn),
    .i_MemData(i_MemData), .i_MemReady(i_MemReady), .o_Err(o_Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every ready pulse pops one expected response.
  always @(negedge clk) begin
    if (o_IReady || o_DReady) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stray_ready: IReady=%0b DReady=%0b, required no pulse", o_IReady, o_DReady);
      end else begin
        mon_e = exp_q.pop_front();
        if (o_IReady && o_DReady) begin
          errors++;
          $display("FAIL both_ready: IReady=1 DReady=1, required one side");
        end else if (o_DReady !== mon_e.is_d) begin
          errors++;
          $display("FAIL ready_side: DReady=%0b IReady=%0b, required D=%0b", o_DReady, o_IReady, mon_e.is_d);
        end else if (mon_e.is_d && o_DData !== mon_e.data[31:0]) begin
          errors++;
          $display("FAIL d_data: got %h, required %h", o_DData, mon_e.data[31:0]);
        end else if (!mon_e.is_d && o_IData !== mon_e.data) begin
          errors++;
          $display("FAIL i_data: got %h, required %h", o_IData, mon_e.data);
        end
      end
    end else begin
      checks++;
      if (o_IData !== '0 || o_DData !== '0) begin
        errors++;
        $display("FAIL idle_data: IData=%h DData=%h, required 0", o_IData, o_DData);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory model: completes after lat rising edges, for one cycle.
  task automatic mem_reply(input int lat, input logic [BW-1:0] d);
    repeat (lat) @(posedge clk);
    #1;
    i_MemReady = 1'b1;
    i_MemData  = d;
    @(posedge clk);
    #1;
    i_MemReady = 1'b0;
    i_MemData  = '0;
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({o_MemReq, o_MemWe, o_MemByteEn, o_Err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: req=%0b we=%0b be=%h err=%0b, required 0", o_MemReq, o_MemWe, o_MemByteEn, o_Err);
    end
    checks++;
    if (o_MemAddr !== '0 || o_MemWData !== '0) begin
      errors++;
      $display("FAIL reset_latch: addr=%h wdata=%h, required 0", o_MemAddr, o_MemWData);
    end
    step();
    i_rst = 1'b1;
    @(negedge clk);
    checks++;
    if (o_MemReq !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_req: got %0b, required 0", o_MemReq);
    end
  endtask

  task automatic test_i_read();
    step();
    i_IAddr = 32'h0000_0104;
    i_IReq  = 1'b1;
    exp_q.push_back('{is_d: 1'b0, data: 64'hCAFE0001_12345678});
    @(negedge clk);
    checks++;
    if (o_MemReq !== 1'b0) begin
      errors++;
      $display("FAIL i_req_latency: MemReq=%0b in request cycle, required 0", o_MemReq);
    end
    step();
    @(negedge clk);
    checks++;
    if (o_MemReq !== 1'b1 || o_MemAddr !== 32'h104 || o_MemByteEn !== 4'hF || o_MemWe !== 1'b0) begin
      errors++;
      $display("FAIL i_grant: req=%0b addr=%h be=%h we=%0b, required 1 104 f 0", o_MemReq, o_MemAddr, o_MemByteEn, o_MemWe);
    end
    mem_reply(3, 64'hCAFE0001_12345678);
    i_IReq = 1'b0;
    @(negedge clk);
    checks++;
    if (o_MemReq !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL i_complete: req=%0b pending=%0d, required 0 0", o_MemReq, exp_q.size());
    end
  endtask

  task automatic test_d_write();
    step();
    i_DAddr = 32'h203; i_DWe = 1'b1; i_DWData = 32'hDEADBEEF; i_DByteEn = 4'b0011;
    i_DReq  = 1'b1;
    exp_q.push_back('{is_d: 1'b1, data: '0});
    step();
    @(negedge clk);
    checks++;
    if (o_MemAddr !== 32'h200 || o_MemWe !== 1'b1 || o_MemWData !== 32'hDEADBEEF || o_MemByteEn !== 4'b0011) begin
      errors++;
      $display("FAIL d_write_grant: addr=%h we=%0b wd=%h be=%b, required 200 1 deadbeef 0011", o_MemAddr, o_MemWe, o_MemWData, o_MemByteEn);
    end
    i_DAddr = 32'hFFC; i_DWe = 1'b0; i_DWData = 32'h0; i_DByteEn = 4'hF;
    step();
    @(negedge clk);
    checks++;
    if (o_MemAddr !== 32'h200 || o_MemWe !== 1'b1 || o_MemWData !== 32'hDEADBEEF || o_MemByteEn !== 4'b0011) begin
      errors++;
      $display("FAIL d_write_stable: addr=%h we=%0b wd=%h be=%b, required 200 1 deadbeef 0011", o_MemAddr, o_MemWe, o_MemWData, o_MemByteEn);
    end
    mem_reply(1, 64'h5555AAAA_5555AAAA);
    i_DReq = 1'b0;
    @(negedge clk);
    checks++;
    if (o_MemReq !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL d_write_done: req=%0b pending=%0d, required 0 0", o_MemReq, exp_q.size());
    end
  endtask

  task automatic test_d_read();
    logic [`XLEN-1:0] addrs [2];
    logic [`XLEN-1:0] aligned [2];
    logic [31:0]      words [2];
    addrs[0] = 32'h2004; aligned[0] = 32'h2004; words[0] = 32'hAAAA0001;
    addrs[1] = 32'h2002; aligned[1] = 32'h2000; words[1] = 32'hBBBB0000;
    for (int n = 0; n < 2; n++) begin
      step();
      i_DAddr = addrs[n]; i_DWe = 1'b0; i_DByteEn = 4'hF; i_DReq = 1'b1;
      exp_q.push_back('{is_d: 1'b1, data: {32'h0, words[n]}});
      step();
      @(negedge clk);
      checks++;
      if (o_MemAddr !== aligned[n] || o_MemWe !== 1'b0) begin
        errors++;
        $display("FAIL d_read_addr%0d: addr=%h we=%0b, required %h 0", n, o_MemAddr, o_MemWe, aligned[n]);
      end
      // Requester withdraws mid-transaction; the response must still arrive.
      i_DReq = 1'b0;
      mem_reply(2, 64'hAAAA0001_BBBB0000);
      @(negedge clk);
      checks++;
      if (o_MemReq !== 1'b0 || exp_q.size() != 0) begin
        errors++;
        $display("FAIL d_read_done%0d: req=%0b pending=%0d, required 0 0", n, o_MemReq, exp_q.size());
      end
    end
  endtask

  task automatic test_tie();
    logic win_d;
    logic [BW-1:0] d;
    step();
    i_IAddr = 32'h1000; i_DAddr = 32'h3000; i_DWe = 1'b0;
    i_IReq = 1'b1; i_DReq = 1'b1;
    for (int r = 0; r < 5; r++) begin
      if (r == 4) i_DReq = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      win_d = (r < 4) ? ((r % 2) == 0) : 1'b0;
`else
      win_d = (r < 4);
`endif
      d = {32'h7000_0000 + 32'(r), 32'h6000_0000 + 32'(r)};
      exp_q.push_back('{is_d: win_d, data: win_d ? {32'h0, d[31:0]} : d});
      @(negedge clk);
      checks++;
      if (o_MemReq !== 1'b0) begin
        errors++;
        $display("FAIL tie_idle%0d: MemReq=%0b, required 0", r, o_MemReq);
      end
      step();
      @(negedge clk);
      checks++;
      if (o_MemAddr !== (win_d ? 32'h3000 : 32'h1000)) begin
        errors++;
        $display("FAIL tie_grant%0d: addr=%h, required %h", r, o_MemAddr, win_d ? 32'h3000 : 32'h1000);
      end
      mem_reply(1, d);
      if (r == 4) i_IReq = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (o_MemReq !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL tie_done: req=%0b pending=%0d, required 0 0", o_MemReq, exp_q.size());
    end
  endtask

  task automatic test_timeout_edge();
    step();
    i_DAddr = 32'h40; i_DWe = 1'b0; i_DReq = 1'b1;
    exp_q.push_back('{is_d: 1'b1, data: {32'h0, 32'h0BAD_F00D}});
    step();
    @(negedge clk);
    // Response lands in the eighth serve cycle, the watchdog's last one.
    mem_reply(TO - 1, {32'h1, 32'h0BAD_F00D});
    i_DReq = 1'b0;
    @(negedge clk);
    checks++;
    if (o_Err !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_edge: err=%0b pending=%0d, required 0 0", o_Err, exp_q.size());
    end
  endtask

  task automatic test_timeout();
    int serve;
    int pulse_at;
    serve = 0;
    pulse_at = -1;
    step();
    i_IAddr = 32'h80; i_IReq = 1'b1;
    i_MemData = {BW{1'b1}};
    exp_q.push_back('{is_d: 1'b0, data: '0});
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_MemReq) serve++;
      if (o_IReady) begin
        pulse_at = serve;
        break;
      end
      @(posedge clk);
    end
    step();
    i_IReq = 1'b0;
    i_MemData = '0;
    checks++;
    if (pulse_at != TO) begin
      errors++;
      $display("FAIL timeout_pulse: pulse in serve cycle %0d, required %0d", pulse_at, TO);
    end
    @(negedge clk);
    checks++;
    if (o_Err !== 1'b1 || o_MemReq !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err: err=%0b req=%0b, required 1 0", o_Err, o_MemReq);
    end
    step();
    i_DAddr = 32'h10; i_DWe = 1'b0; i_DReq = 1'b1;
    exp_q.push_back('{is_d: 1'b1, data: {32'h0, 32'h1234_5678}});
    step();
    @(negedge clk);
    mem_reply(1, {32'h0, 32'h1234_5678});
    i_DReq = 1'b0;
    @(negedge clk);
    checks++;
    if (o_Err !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL err_sticky: err=%0b pending=%0d, required 1 0", o_Err, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    step();
    i_IAddr = 32'h500; i_IReq = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (o_MemReq !== 1'b1 || o_MemAddr !== 32'h500) begin
      errors++;
      $display("FAIL rst_mid_serve: req=%0b addr=%h, required 1 500", o_MemReq, o_MemAddr);
    end
    step();
    i_rst = 1'b0;
    i_IReq = 1'b0;
    step();
    i_rst = 1'b1;
    @(negedge clk);
    checks++;
    if (o_MemReq !== 1'b0 || o_Err !== 1'b0 || o_MemAddr !== '0) begin
      errors++;
      $display("FAIL rst_mid_idle: req=%0b err=%0b addr=%h, required 0 0 0", o_MemReq, o_Err, o_MemAddr);
    end
    step();
    i_MemReady = 1'b1;
    i_MemData  = {BW{1'b1}};
    @(negedge clk);
    checks++;
    if (o_IReady !== 1'b0 || o_DReady !== 1'b0) begin
      errors++;
      $display("FAIL stray_mem_ready: IReady=%0b DReady=%0b, required 0 0", o_IReady, o_DReady);
    end
    step();
    i_MemReady = 1'b0;
    i_MemData  = '0;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || o_MemReq !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_end: pending=%0d req=%0b, required 0 0", exp_q.size(), o_MemReq);
    end
  endtask

  initial begin
    i_rst = 1'b0; i_IReq = 1'b0; i_IAddr = '0; i_DReq = 1'b0; i_DWe = 1'b0;
    i_DAddr = '0; i_DWData = '0; i_DByteEn = '0; i_MemData = '0; i_MemReady = 1'b0;
    test_reset();
    test_i_read();
    test_d_write();
    test_d_read();
    test_tie();
    test_timeout_edge();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
